// File: rtl/uart_receiver.sv
// uart_receiver: serial-to-parallel UART receiver.
//   Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
//   The line is oversampled at CLKS_PER_BIT clk cycles per bit and sampled at mid-bit.
// Ports:
//   clk        clock
//   rst_n      asynchronous reset, active-low
//   rx         serial line, idles high, asynchronous to clk
//   rx_data    last good byte, held until the next good frame
//   rx_valid   1-cycle pulse: rx_data updated this cycle
//   frame_err  1-cycle pulse: stop bit sampled 0, byte discarded
//   rx_busy    high whenever the receiver is not idle
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLast = CntW'(HALF - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            sync1_q, sync2_q;
    logic            rx_s;

    // Two-flop synchroniser; resets to the idle (high) line level so reset
    // release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                // Re-check the line at mid start bit to reject short glitches.
                if (cnt_q == HalfLast) begin
                    if (!rx_s) begin
                        state_d   = StData;
                        cnt_d     = '0;
                        bit_idx_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    shift_d[bit_idx_q] = rx_s;
                    cnt_d              = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StStop: begin
                // Leaving at mid stop bit leaves half a bit of slack for the
                // next start edge in back-to-back traffic.
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StBreak: begin
                // Wait out a held-low line so a break gives one error, not a
                // stream of false starts.
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = (state_q != StIdle);

endmodule

// File: tb/tb_uart_receiver.sv
// Testbench for uart_receiver: directed frames, scoreboard of expected pulses
// checked by an independent monitor on rx_valid / frame_err.
module tb_uart_receiver;

    localparam int unsigned CPB = 8;
    localparam int unsigned LAT = 2 + CPB / 2 + 9 * CPB;  // 78

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    uart_receiver #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        int         cyc;    // expected posedge count of the pulse, 0 = unchecked
    } exp_t;

    exp_t       sb[$];
    int         n_cmp  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    logic [7:0] last_good = 8'h00;
    logic       prev_pulse = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per output pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid || frame_err) begin
                chk("pulse_exclusive", {31'd0, rx_valid && frame_err}, 32'd0);
                chk("pulse_not_back_to_back", {31'd0, prev_pulse}, 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {31'd0, frame_err, rx_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pulse_kind", {31'd0, frame_err}, {31'd0, e.is_err});
                    chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                    if (e.cyc != 0) chk("latency_cycle", cyc, e.cyc);
                end
            end
            prev_pulse <= rx_valid || frame_err;
        end else begin
            prev_pulse <= 1'b0;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_cycles(CPB);
    endtask

    // Sends one frame; pushes the expected pulse before driving the start bit.
    task automatic send_frame(input logic [7:0] data, input logic stop, input logic chk_lat);
        exp_t e;
        e.is_err = ~stop;
        e.data   = stop ? data : last_good;
        e.cyc    = chk_lat ? (cyc + 1 + int'(LAT)) : 0;
        if (stop) last_good = data;
        sb.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(stop);
    endtask

    task automatic drain(input string name, input int budget);
        int b;
        b = budget;
        while (sb.size() != 0 && b > 0) begin
            @(posedge clk);
            b--;
        end
        #1;
        chk(name, sb.size(), 32'd0);
    endtask

    initial begin
        logic [7:0] f0;
        rst_n = 1'b0;
        rx    = 1'b1;

        // 1: reset with the line toggling
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            rx = ~rx;
            wait_cycles(1);
        end
        chk("reset_rx_data", {24'd0, rx_data}, 32'h00);
        chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
        chk("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
        rx    = 1'b1;
        rst_n = 1'b1;
        wait_cycles(5);
        chk("idle_after_reset", {31'd0, rx_busy}, 32'd0);

        // 2: single frame with latency check
        send_frame(8'hA5, 1'b1, 1'b1);
        wait_cycles(4);
        drain("drain_single", 200);

        // 3: back-to-back frames
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0);
        wait_cycles(4);
        drain("drain_b2b", 200);

        // 4: 2-cycle glitch is rejected
        rx = 1'b0;
        wait_cycles(2);
        rx = 1'b1;
        wait_cycles(2);
        chk("glitch_busy", {31'd0, rx_busy}, 32'd1);
        wait_cycles(10);
        chk("glitch_idle", {31'd0, rx_busy}, 32'd0);
        chk("glitch_rx_data", {24'd0, rx_data}, 32'h81);
        send_frame(8'h3C, 1'b1, 1'b0);
        wait_cycles(4);
        drain("drain_glitch", 200);

        // 5: framing error followed by a break
        send_frame(8'hC3, 1'b0, 1'b0);
        rx = 1'b0;
        wait_cycles(40);
        chk("break_busy", {31'd0, rx_busy}, 32'd1);
        rx = 1'b1;
        wait_cycles(16);
        chk("break_idle", {31'd0, rx_busy}, 32'd0);
        chk("break_rx_data", {24'd0, rx_data}, 32'h3C);
        send_frame(8'h11, 1'b1, 1'b0);
        wait_cycles(4);
        drain("drain_framing", 200);

        // 6: reset during data bit 4 of 0xF0
        f0 = 8'hF0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(f0[i]);
        rx = f0[4];
        wait_cycles(4);
        rst_n = 1'b0;
        last_good = 8'h00;
        rx = 1'b1;
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(1);
        chk("midreset_idle", {31'd0, rx_busy}, 32'd0);
        chk("midreset_rx_data", {24'd0, rx_data}, 32'h00);
        wait_cycles(20);
        chk("midreset_no_pulse_busy", {31'd0, rx_busy}, 32'd0);
        send_frame(8'h0F, 1'b1, 1'b0);
        wait_cycles(4);
        drain("drain_midreset", 200);
        chk("final_rx_data", {24'd0, rx_data}, 32'h0F);

        wait_cycles(20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
